// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - raw key pins in, conditioned key levels and strobes out
interface key_conditioner_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] key_in;
  logic [N_CH-1:0] held;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] fire;

  // master: the board pin side that drives key_in and consumes the events
  modport master (output key_in, input held, press, release_pulse, fire);
  // slave: the conditioner itself
  modport slave (input key_in, output held, press, release_pulse, fire);
endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - per-channel key synchroniser, debouncer, edge pulses; auto-repeat under KEY_AUTOREPEAT_EN
module key_conditioner #(
  parameter int N_CH       = 4,
  parameter int DEB_CYCLES = 500000,
  parameter int DAS_CYCLES = 8333333,
  parameter int ARR_CYCLES = 2500000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  key_conditioner_if.slave kif
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  // The counter holds the mismatch run length; the level flips on the edge
  // where a run that has already reached DEB_CYCLES is still mismatching.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES);
  localparam logic [N_CH-1:0]  REL_LVL  = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

  if (DEB_CYCLES < 1 || DAS_CYCLES < 2 || ARR_CYCLES < 1) begin : g_bad_params
    $error("key_conditioner: illegal DEB/DAS/ARR cycle parameters");
  end

  logic [N_CH-1:0]  sync1_q, sync1_d;
  logic [N_CH-1:0]  sync2_q, sync2_d;
  logic [N_CH-1:0]  held_q, held_d;
  logic [N_CH-1:0]  press_q, press_d;
  logic [N_CH-1:0]  release_q, release_d;
  logic [N_CH-1:0]  p;
  logic [DEB_W-1:0] deb_cnt_q [N_CH];
  logic [DEB_W-1:0] deb_cnt_d [N_CH];

  // pressed-level view of the synchronised pin, 1 = pressed
  assign p = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  // synchroniser shift, debounce counters and held-level edge detection
  always_comb begin
    sync1_d = kif.key_in;
    sync2_d = sync1_q;
    held_d  = held_q;
    for (int i = 0; i < N_CH; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (p[i] == held_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        held_d[i]    = ~held_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
      end
    end
    press_d   = held_d & ~held_q;
    release_d = ~held_d & held_q;
  end

  // input path and debounce state; sync flops reset to the released pin level
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q   <= REL_LVL;
      sync2_q   <= REL_LVL;
      held_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_CH; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N_CH; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  assign kif.held          = held_q;
  assign kif.press         = press_q;
  assign kif.release_pulse = release_q;

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_MAX = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DAS_LAST = REP_W'(DAS_CYCLES - 1);
  localparam logic [REP_W-1:0] ARR_LAST = REP_W'(ARR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  rep_state_e       st_q [N_CH];
  rep_state_e       st_d [N_CH];
  logic [REP_W-1:0] rep_cnt_q [N_CH];
  logic [REP_W-1:0] rep_cnt_d [N_CH];
  logic [N_CH-1:0]  rep_pulse;

  // repeat FSM state and counter registers
  always_ff @(posedge CLOCK_50) begin
    for (int i = 0; i < N_CH; i++) begin
      if (reset) begin
        st_q[i]      <= ST_IDLE;
        rep_cnt_q[i] <= '0;
      end else begin
        st_q[i]      <= st_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end

  // next state: release wins; counter clears on every state change and repeat pulse
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]      = st_q[i];
      rep_cnt_d[i] = rep_cnt_q[i];
      case (st_q[i])
        ST_IDLE: begin
          if (press_q[i]) begin
            st_d[i]      = ST_DELAY;
            rep_cnt_d[i] = '0;
          end
        end
        ST_DELAY: begin
          if (release_q[i]) begin
            st_d[i]      = ST_IDLE;
            rep_cnt_d[i] = '0;
          end else if (rep_cnt_q[i] == DAS_LAST) begin
            st_d[i]      = ST_REPEAT;
            rep_cnt_d[i] = '0;
          end else begin
            rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
          end
        end
        ST_REPEAT: begin
          if (release_q[i]) begin
            st_d[i]      = ST_IDLE;
            rep_cnt_d[i] = '0;
          end else if (rep_cnt_q[i] == ARR_LAST) begin
            rep_cnt_d[i] = '0;
          end else begin
            rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
          end
        end
        default: begin
          st_d[i]      = ST_IDLE;
          rep_cnt_d[i] = '0;
        end
      endcase
    end
  end

  // repeat pulse on the terminal count, suppressed in the release cycle
  always_comb begin
    rep_pulse = '0;
    for (int i = 0; i < N_CH; i++) begin
      rep_pulse[i] = !release_q[i] &&
                     (((st_q[i] == ST_DELAY)  && (rep_cnt_q[i] == DAS_LAST)) ||
                      ((st_q[i] == ST_REPEAT) && (rep_cnt_q[i] == ARR_LAST)));
    end
  end

  assign kif.fire = press_q | rep_pulse;
`else
  assign kif.fire = press_q;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - table, directed and random checks of key_conditioner against a reference model
`timescale 1ns/1ps
module tb_key_conditioner;

  localparam int N_CH = 4;
  localparam int DEB  = 4;
  localparam int DAS  = 10;
  localparam int ARR  = 3;
  localparam int MAXT = 4096;

`ifdef KEY_AUTOREPEAT_EN
  localparam int EXP_HOLD_FIRES = 11;
  localparam int EXP_DUAL_FIRES = 6;
`else
  localparam int EXP_HOLD_FIRES = 1;
  localparam int EXP_DUAL_FIRES = 1;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  key_conditioner_if #(.N_CH(N_CH)) kif ();

  key_conditioner #(
    .N_CH      (N_CH),
    .DEB_CYCLES(DEB),
    .DAS_CYCLES(DAS),
    .ARR_CYCLES(ARR),
    .ACTIVE_LOW(1)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .kif     (kif.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] pin_h [MAXT];
  bit         rst_h [MAXT];
  int         t = 0;
  logic [3:0] m_held = '0, m_press = '0, m_rel = '0, m_fire = '0;
  int         last_chg [N_CH];
  int         press_t  [N_CH];

  typedef struct {
    logic [3:0] kin;
    bit         r;
    logic [3:0] held;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] fire;
  } vec_t;

  vec_t tbl [30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %h, expected %h", name, t, act, exp);
  endtask

  // pressed level seen by the debouncer on edge e: pin from two edges earlier, released after reset
  function automatic bit p_at(input int e, input int ch);
    if (e < 2) return 1'b0;
    if (rst_h[e-1] || rst_h[e-2]) return 1'b0;
    return ~pin_h[e-2][ch];
  endfunction

  task automatic model_edge(input logic [3:0] kin, input bit r);
    bit flip;
    int d;
    pin_h[t] = kin;
    rst_h[t] = r;
    m_press  = '0;
    m_rel    = '0;
    m_fire   = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (r) begin
        m_held[ch]   = 1'b0;
        last_chg[ch] = t;
        press_t[ch]  = -1;
      end else begin
        // accept a new level once it has disagreed with held on DEB+1 edges in a row
        flip = (t - last_chg[ch]) >= (DEB + 1);
        for (int k = 0; k <= DEB; k++)
          if (flip && (p_at(t - k, ch) == m_held[ch])) flip = 1'b0;
        if (flip) begin
          m_held[ch]   = ~m_held[ch];
          last_chg[ch] = t;
          if (m_held[ch]) begin
            m_press[ch] = 1'b1;
            press_t[ch] = t;
          end else begin
            m_rel[ch]   = 1'b1;
            press_t[ch] = -1;
          end
        end
`ifdef KEY_AUTOREPEAT_EN
        if (m_held[ch] && press_t[ch] >= 0) begin
          d = t - press_t[ch];
          if (d == DAS || (d > DAS && ((d - DAS) % ARR) == 0)) m_fire[ch] = 1'b1;
        end
`endif
        if (m_press[ch]) m_fire[ch] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic [3:0] kin, input bit r);
    @(negedge clk);
    kif.key_in = kin;
    reset      = r;
    @(posedge clk);
    model_edge(kin, r);
    #1;
    chk("model", {kif.held, kif.press, kif.release_pulse, kif.fire},
                 {m_held, m_press, m_rel, m_fire});
    t++;
  endtask

  initial begin
    logic [3:0] kin;
    logic [3:0] cur;
    int n_cnt, n_fire, n_rel, n_late, n_lock;

    kif.key_in = 4'hF;

    // reset, clean press/release of ch0 (repeat due on the release cycle), 3-cycle ch2 glitch
    for (int i = 0; i < 30; i++) begin
      tbl[i].r     = (i < 2);
      tbl[i].kin   = (i < 2) ? 4'hF : (i < 12) ? 4'hE : (i < 20) ? 4'hF : (i < 23) ? 4'hB : 4'hF;
      tbl[i].held  = (i >= 8 && i < 18) ? 4'h1 : 4'h0;
      tbl[i].press = (i == 8)  ? 4'h1 : 4'h0;
      tbl[i].rel   = (i == 18) ? 4'h1 : 4'h0;
      tbl[i].fire  = (i == 8)  ? 4'h1 : 4'h0;
    end
    for (int i = 0; i < 30; i++) begin
      step(tbl[i].kin, tbl[i].r);
      chk($sformatf("table[%0d]", i), {kif.held, kif.press, kif.release_pulse, kif.fire},
          {tbl[i].held, tbl[i].press, tbl[i].rel, tbl[i].fire});
    end

    // ch1 bounces every 2 cycles, then settles low
    n_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      kin    = 4'hF;
      kin[1] = ((k / 2) % 2) != 0;
      step(kin, 1'b0);
      n_cnt += int'(kif.press[1]);
    end
    for (int j = 0; j < 6; j++) begin
      step(4'hD, 1'b0);
      n_cnt += int'(kif.press[1]);
    end
    chk("bounce_no_press", n_cnt, 0);
    step(4'hD, 1'b0);
    chk("settle_press", kif.press[1], 1);

    // hold ch1 for 40 cycles of held, then release
    n_fire = int'(kif.fire[1]);
    n_rel  = 0;
    n_late = 0;
    for (int d = 1; d < 50; d++) begin
      step((d < 34) ? 4'hD : 4'hF, 1'b0);
      n_fire += int'(kif.fire[1]);
      n_rel  += int'(kif.release_pulse[1]);
      if (d >= 40) n_late += int'(kif.fire[1]);
    end
    chk("hold_fire_count", n_fire, EXP_HOLD_FIRES);
    chk("hold_release_count", n_rel, 1);
    chk("fire_after_release", n_late, 0);

    // ch0 and ch3 together, then a 1-cycle reset during REPEAT with keys still down
    for (int j = 0; j < 3; j++) step(4'hF, 1'b0);
    n_cnt  = 0;
    n_lock = 0;
    for (int j = 0; j < 30; j++) begin
      step(4'h6, 1'b0);
      if (j == 6) chk("dual_press", {kif.press[3], kif.press[0]}, 2'b11);
      n_cnt += int'(kif.fire[0]);
      if (kif.fire[0] != kif.fire[3]) n_lock++;
    end
    chk("dual_fire_count", n_cnt, EXP_DUAL_FIRES);
    chk("dual_lockstep", n_lock, 0);
    step(4'h6, 1'b1);
    chk("reset_clears", {kif.held, kif.press, kif.release_pulse, kif.fire}, 16'h0000);
    n_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      step(4'h6, 1'b0);
      if (j < 6) n_cnt += int'(kif.press != 4'h0);
      if (j == 6) chk("repress_after_reset", kif.press, 4'h9);
    end
    chk("no_early_repress", n_cnt, 0);
    for (int j = 0; j < 10; j++) step(4'hF, 1'b0);

    // random pins: busy phase then slow phase, occasional reset
    cur = 4'hF;
    for (int n = 0; n < 1500; n++) begin
      int div;
      div = (n < 750) ? 6 : 25;
      for (int ch = 0; ch < N_CH; ch++)
        if ($urandom_range(0, div - 1) == 0) cur[ch] = ~cur[ch];
      step(cur, $urandom_range(0, 249) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
